memory_bus_arbiter: RTL and testbench

Shares one `MemoryBus` slave port between `MASTERS` upstream memory masters. It uses round-robin arbitration on the request channel and a one-entry registered output stage. Responses are routed back to the issuing master using master-index bits that the arbiter prepends to the transaction ID. It sits between the per-core `MemoryMaster` instances and the memory controller.

---
 rtl/memory_bus_pkg.sv | 16 +
 rtl/memory_bus_arbiter_picker.sv | 30 +++
 rtl/memory_bus_arbiter.sv | 88 ++++++++
 tb/tb_memory_bus_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_bus_pkg.sv
// memory_bus_pkg: shared widths, index-width helper and request record for the memory bus arbiter
package memory_bus_pkg;
  localparam int DEFAULT_MASTERS       = 4;
  localparam int DEFAULT_ADDRESS_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_ID_WIDTH      = 8;
  function automatic int index_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  typedef struct packed {
    logic [DEFAULT_ADDRESS_WIDTH-1:0] address;
    logic [DEFAULT_DATA_WIDTH-1:0]    data;
    logic                             write;
    logic [DEFAULT_ID_WIDTH-1:0]      id;
  } memory_request_t;
endpackage

// File: rtl/memory_bus_arbiter_picker.sv
// round_robin_picker: combinational round-robin grant, scanning upward from last+1 with wrap
module round_robin_picker
  import memory_bus_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = index_width(N)
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] last,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          any
);
  int pos;
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(last) + k) % N;
      if (enable && !any && request[pos]) begin
        grant[pos] = 1'b1;
        index      = IW'(pos);
        any        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: round-robin share of one memory bus port with a one-entry output register and ID-based response routing
module memory_bus_arbiter
  import memory_bus_pkg::*;
#(
  parameter int MASTERS       = DEFAULT_MASTERS,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ID_WIDTH      = DEFAULT_ID_WIDTH,
  localparam int INDEX_WIDTH  = index_width(MASTERS)
) (
  input  logic                            clock,
  input  logic                            resetN,
  input  logic [MASTERS-1:0]              msValid,
  output logic [MASTERS-1:0]              msTaken,
  input  logic [ADDRESS_WIDTH-1:0]        msAddress [MASTERS],
  input  logic [DATA_WIDTH-1:0]           msData    [MASTERS],
  input  logic [ID_WIDTH-1:0]             msID      [MASTERS],
  input  logic [MASTERS-1:0]              msWrite,
  output logic [MASTERS-1:0]              smValid,
  input  logic [MASTERS-1:0]              smTaken,
  output logic [DATA_WIDTH-1:0]           smData,
  output logic [ID_WIDTH-1:0]             smID,
  output logic                            dsMsValid,
  input  logic                            dsMsTaken,
  output logic [ADDRESS_WIDTH-1:0]        dsMsAddress,
  output logic [DATA_WIDTH-1:0]           dsMsData,
  output logic                            dsMsWrite,
  output logic [ID_WIDTH+INDEX_WIDTH-1:0] dsMsID,
  input  logic                            dsSmValid,
  output logic                            dsSmTaken,
  input  logic [DATA_WIDTH-1:0]           dsSmData,
  input  logic [ID_WIDTH+INDEX_WIDTH-1:0] dsSmID,
  output logic                            badResponse
);
  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0]        address;
    logic [DATA_WIDTH-1:0]           data;
    logic                            write;
    logic [ID_WIDTH+INDEX_WIDTH-1:0] id;
  } request_t;
  request_t                 stage, winner;
  logic                     full, load, pick_any;
  logic [INDEX_WIDTH-1:0]   last, pick_index, route;
  logic [MASTERS-1:0]       pick_grant;
  logic                     in_range;
  assign load = !full || dsMsTaken;
  round_robin_picker #(.N(MASTERS)) picker (
    .request(msValid),
    .last(last),
    .enable(load),
    .grant(pick_grant),
    .index(pick_index),
    .any(pick_any)
  );
  assign msTaken = pick_grant;
  assign winner  = '{address: msAddress[pick_index], data: msData[pick_index],
                     write: msWrite[pick_index], id: {pick_index, msID[pick_index]}};
  // A load cycle with no requester drains the register rather than holding it.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      full  <= 1'b0;
      last  <= INDEX_WIDTH'(MASTERS - 1);
      stage <= '0;
    end else if (load) begin
      full <= pick_any;
      if (pick_any) begin
        last  <= pick_index;
        stage <= winner;
      end
    end
  end
  assign dsMsValid   = full;
  assign dsMsAddress = stage.address;
  assign dsMsData    = stage.data;
  assign dsMsWrite   = stage.write;
  assign dsMsID      = stage.id;
  // Responses carrying an index with no master behind it are swallowed and flagged.
  assign route    = dsSmID[ID_WIDTH +: INDEX_WIDTH];
  assign in_range = int'(route) < MASTERS;
  always_comb begin
    smValid = '0;
    for (int i = 0; i < MASTERS; i++) smValid[i] = dsSmValid && (int'(route) == i);
  end
  assign dsSmTaken   = in_range ? smTaken[route] : 1'b1;
  assign badResponse = dsSmValid && !in_range;
  assign smData      = dsSmData;
  assign smID        = dsSmID[ID_WIDTH-1:0];
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter: directed checks of arbitration, stall, routing and reset of memory_bus_arbiter
module tb_memory_bus_arbiter;
  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic [3:0]  msValid = '0, msTaken, msWrite = '0, smValid, smTaken = '0;
  logic [31:0] msAddress [4];
  logic [31:0] msData [4];
  logic [7:0]  msID [4];
  logic [31:0] smData, dsMsAddress, dsMsData, dsSmData = '0;
  logic [7:0]  smID;
  logic        dsMsValid, dsMsTaken = 1'b0, dsMsWrite, dsSmValid = 1'b0, dsSmTaken, badResponse;
  logic [9:0]  dsMsID, dsSmID = '0;
  logic [2:0]  msValid3 = '0, msTaken3, msWrite3 = '0, smValid3, smTaken3 = '0;
  logic [31:0] msAddress3 [3];
  logic [31:0] msData3 [3];
  logic [7:0]  msID3 [3];
  logic [31:0] smData3, dsMsAddress3, dsMsData3, dsSmData3 = '0;
  logic [7:0]  smID3;
  logic        dsMsValid3, dsMsWrite3, dsSmValid3 = 1'b0, dsSmTaken3, badResponse3;
  logic [9:0]  dsMsID3, dsSmID3 = '0;
  int total = 0, bad = 0;

  always #5 clock = ~clock;

  memory_bus_arbiter #(.MASTERS(4)) dut (
    .clock(clock), .resetN(resetN), .msValid(msValid), .msTaken(msTaken),
    .msAddress(msAddress), .msData(msData), .msID(msID), .msWrite(msWrite),
    .smValid(smValid), .smTaken(smTaken), .smData(smData), .smID(smID),
    .dsMsValid(dsMsValid), .dsMsTaken(dsMsTaken), .dsMsAddress(dsMsAddress),
    .dsMsData(dsMsData), .dsMsWrite(dsMsWrite), .dsMsID(dsMsID),
    .dsSmValid(dsSmValid), .dsSmTaken(dsSmTaken), .dsSmData(dsSmData),
    .dsSmID(dsSmID), .badResponse(badResponse)
  );

  memory_bus_arbiter #(.MASTERS(3)) dut3 (
    .clock(clock), .resetN(resetN), .msValid(msValid3), .msTaken(msTaken3),
    .msAddress(msAddress3), .msData(msData3), .msID(msID3), .msWrite(msWrite3),
    .smValid(smValid3), .smTaken(smTaken3), .smData(smData3), .smID(smID3),
    .dsMsValid(dsMsValid3), .dsMsTaken(1'b0), .dsMsAddress(dsMsAddress3),
    .dsMsData(dsMsData3), .dsMsWrite(dsMsWrite3), .dsMsID(dsMsID3),
    .dsSmValid(dsSmValid3), .dsSmTaken(dsSmTaken3), .dsSmData(dsSmData3),
    .dsSmID(dsSmID3), .badResponse(badResponse3)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    msValid = '0;
    dsMsTaken = 1'b0;
    resetN = 1'b0;
    #1;
    total++; if (dsMsValid !== 1'b0) begin bad++; $display("FAIL reset_dsMsValid got=%b exp=0", dsMsValid); end
    total++; if (msTaken !== 4'b0) begin bad++; $display("FAIL reset_msTaken got=%b exp=0000", msTaken); end
    total++; if (badResponse !== 1'b0) begin bad++; $display("FAIL reset_badResponse got=%b exp=0", badResponse); end
    step();
    resetN = 1'b1;
    #1;
  endtask

  task automatic test_two_masters();
    msAddress[0] = 32'h0000_1000; msData[0] = 32'hAAAA_0000; msID[0] = 8'h11;
    msAddress[2] = 32'h0000_2000; msData[2] = 32'hCCCC_0000; msID[2] = 8'h22;
    msWrite = 4'b0100;
    dsMsTaken = 1'b1;
    msValid = 4'b0101;
    #1;
    total++; if (msTaken !== 4'b0001) begin bad++; $display("FAIL two_grant0 got=%b exp=0001", msTaken); end
    step();
    msValid = 4'b0100;
    #1;
    total++; if (msTaken !== 4'b0100) begin bad++; $display("FAIL two_grant2 got=%b exp=0100", msTaken); end
    total++; if (dsMsValid !== 1'b1) begin bad++; $display("FAIL two_valid0 got=%b exp=1", dsMsValid); end
    total++; if (dsMsID !== 10'h011) begin bad++; $display("FAIL two_id0 got=%h exp=011", dsMsID); end
    total++; if (dsMsAddress !== 32'h0000_1000 || dsMsWrite !== 1'b0) begin bad++; $display("FAIL two_fields0 got=%h/%b exp=00001000/0", dsMsAddress, dsMsWrite); end
    step();
    msValid = 4'b0000;
    #1;
    total++; if (dsMsID !== 10'h222) begin bad++; $display("FAIL two_id2 got=%h exp=222", dsMsID); end
    total++; if (dsMsData !== 32'hCCCC_0000 || dsMsWrite !== 1'b1) begin bad++; $display("FAIL two_fields2 got=%h/%b exp=cccc0000/1", dsMsData, dsMsWrite); end
    total++; if (msTaken !== 4'b0000) begin bad++; $display("FAIL two_idle_taken got=%b exp=0000", msTaken); end
    step();
    total++; if (dsMsValid !== 1'b0) begin bad++; $display("FAIL two_drain got=%b exp=0", dsMsValid); end
  endtask

  task automatic test_round_robin();
    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      msAddress[i] = 32'h100 * (i + 1);
      msData[i] = 32'hD0 + i;
      msID[i] = 8'hA0 + 8'(i);
    end
    msWrite = 4'b0000;
    dsMsTaken = 1'b1;
    msValid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1;
      total++; if (msTaken !== (4'b0001 << exp_order[c])) begin bad++; $display("FAIL rr_grant c=%0d got=%b exp_master=%0d", c, msTaken, exp_order[c]); end
      if (c > 0) begin
        total++; if (dsMsValid !== 1'b1) begin bad++; $display("FAIL rr_valid c=%0d got=%b exp=1", c, dsMsValid); end
        total++; if (dsMsID !== {2'(exp_order[c-1]), 8'hA0 + 8'(exp_order[c-1])}) begin bad++; $display("FAIL rr_id c=%0d got=%h exp_master=%0d", c, dsMsID, exp_order[c-1]); end
        total++; if (dsMsAddress !== 32'h100 * (exp_order[c-1] + 1)) begin bad++; $display("FAIL rr_addr c=%0d got=%h", c, dsMsAddress); end
      end
      step();
    end
    msValid = '0;
    #1;
    total++; if (dsMsID !== 10'h1A1 || dsMsValid !== 1'b1) begin bad++; $display("FAIL rr_last got=%h/%b exp=1a1/1", dsMsID, dsMsValid); end
    step();
  endtask

  task automatic test_stall();
    msAddress[3] = 32'h0000_3333; msID[3] = 8'h33;
    msAddress[1] = 32'h0000_1111; msID[1] = 8'h44;
    dsMsTaken = 1'b0;
    msValid = 4'b1000;
    #1;
    total++; if (msTaken !== 4'b1000) begin bad++; $display("FAIL stall_load got=%b exp=1000", msTaken); end
    step();
    msValid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (msTaken !== 4'b0000) begin bad++; $display("FAIL stall_taken c=%0d got=%b exp=0000", c, msTaken); end
      total++; if (dsMsValid !== 1'b1 || dsMsID !== 10'h333 || dsMsAddress !== 32'h0000_3333) begin bad++; $display("FAIL stall_hold c=%0d got=%b/%h/%h exp=1/333/00003333", c, dsMsValid, dsMsID, dsMsAddress); end
      step();
    end
    dsMsTaken = 1'b1;
    #1;
    total++; if (msTaken !== 4'b0010) begin bad++; $display("FAIL stall_release got=%b exp=0010", msTaken); end
    step();
    msValid = '0;
    #1;
    total++; if (dsMsValid !== 1'b1 || dsMsID !== 10'h144) begin bad++; $display("FAIL stall_next got=%b/%h exp=1/144", dsMsValid, dsMsID); end
    step();
    total++; if (dsMsValid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b exp=0", dsMsValid); end
  endtask

  task automatic test_response();
    dsSmValid = 1'b1;
    dsSmID = {2'd2, 8'h5A};
    dsSmData = 32'hDEAD_BEEF;
    smTaken = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (smValid !== 4'b0100) begin bad++; $display("FAIL resp_valid c=%0d got=%b exp=0100", c, smValid); end
      total++; if (dsSmTaken !== 1'b0) begin bad++; $display("FAIL resp_wait c=%0d got=%b exp=0", c, dsSmTaken); end
      total++; if (smID !== 8'h5A || smData !== 32'hDEAD_BEEF) begin bad++; $display("FAIL resp_fields c=%0d got=%h/%h exp=5a/deadbeef", c, smID, smData); end
      step();
    end
    smTaken = 4'b0100;
    #1;
    total++; if (dsSmTaken !== 1'b1 || badResponse !== 1'b0) begin bad++; $display("FAIL resp_taken got=%b/%b exp=1/0", dsSmTaken, badResponse); end
    step();
    dsSmValid = 1'b0;
    smTaken = '0;
    #1;
    total++; if (smValid !== 4'b0000) begin bad++; $display("FAIL resp_idle got=%b exp=0000", smValid); end
  endtask

  task automatic test_bad_response();
    dsSmValid3 = 1'b1;
    dsSmID3 = {2'd2, 8'h66};
    smTaken3 = 3'b000;
    #1;
    total++; if (smValid3 !== 3'b100 || dsSmTaken3 !== 1'b0 || badResponse3 !== 1'b0) begin bad++; $display("FAIL bad_inrange got=%b/%b/%b exp=100/0/0", smValid3, dsSmTaken3, badResponse3); end
    step();
    dsSmID3 = {2'd3, 8'h77};
    #1;
    total++; if (smValid3 !== 3'b000) begin bad++; $display("FAIL bad_smValid got=%b exp=000", smValid3); end
    total++; if (dsSmTaken3 !== 1'b1 || badResponse3 !== 1'b1) begin bad++; $display("FAIL bad_flag got=%b/%b exp=1/1", dsSmTaken3, badResponse3); end
    step();
    dsSmValid3 = 1'b0;
    #1;
    total++; if (badResponse3 !== 1'b0) begin bad++; $display("FAIL bad_pulse got=%b exp=0", badResponse3); end
  endtask

  task automatic test_reset_while_full();
    dsMsTaken = 1'b0;
    msValid = 4'b0100;
    step();
    msValid = '0;
    #1;
    total++; if (dsMsValid !== 1'b1) begin bad++; $display("FAIL rwf_full got=%b exp=1", dsMsValid); end
    resetN = 1'b0;
    #1;
    total++; if (dsMsValid !== 1'b0) begin bad++; $display("FAIL rwf_async got=%b exp=0", dsMsValid); end
    step();
    resetN = 1'b1;
    dsMsTaken = 1'b1;
    msValid = 4'b1111;
    #1;
    total++; if (msTaken !== 4'b0001) begin bad++; $display("FAIL rwf_priority got=%b exp=0001", msTaken); end
    step();
    msValid = '0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin msAddress[i] = '0; msData[i] = '0; msID[i] = '0; end
    for (int i = 0; i < 3; i++) begin msAddress3[i] = '0; msData3[i] = '0; msID3[i] = '0; end
    #2;
    test_reset();
    test_two_masters();
    test_round_robin();
    test_stall();
    test_response();
    test_bad_response();
    test_reset_while_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
